pc_unit: RTL



---
 rtl/pc_pkg.sv | 12 +
 rtl/pc_unit_ras_stack.sv | 60 ++++++
 rtl/pc_unit.sv | 132 +++++++++++++
 3 files changed

// File: rtl/pc_pkg.sv
// Shared definitions for the program-counter unit: next-PC mode encodings
// and the type of the sel field.
package pc_pkg;

    typedef enum logic [1:0] {
        PC_SEQ    = 2'b00,
        PC_BRANCH = 2'b01,
        PC_CALL   = 2'b10,
        PC_RET    = 2'b11
    } pc_sel_e;

endpackage

// File: rtl/pc_unit_ras_stack.sv
// ras_stack: circular return-address stack with a top pointer and a count.
// Ports: clk, reset, push, pop, push_data, pop_data (current top), count,
// full, empty. A push while full overwrites the oldest entry.
module ras_stack #(
    parameter int W     = 32,
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       push,
    input  logic                       pop,
    input  logic [W-1:0]               push_data,
    output logic [W-1:0]               pop_data,
    output logic [$clog2(DEPTH+1)-1:0] count,
    output logic                       full,
    output logic                       empty
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);
    localparam logic [PW-1:0] LAST = PW'(DEPTH - 1);
    localparam logic [CW-1:0] MAXC = CW'(DEPTH);

    logic [W-1:0]  mem [DEPTH];
    logic [PW-1:0] ptr;
    logic [PW-1:0] ptr_inc;
    logic [PW-1:0] ptr_dec;

    // ptr is the next free slot; when full it points at the oldest entry,
    // so a push there overwrites it.
    always_comb begin
        ptr_inc = (ptr == LAST) ? '0 : ptr + 1'b1;
        ptr_dec = (ptr == '0) ? LAST : ptr - 1'b1;
    end

    assign full     = (count == MAXC);
    assign empty    = (count == '0);
    assign pop_data = mem[ptr_dec];

    always_ff @(posedge clk) begin
        if (reset) begin
            ptr   <= '0;
            count <= '0;
        end else if (push) begin
            ptr <= ptr_inc;
            if (!full)
                count <= count + 1'b1;
        end else if (pop && !empty) begin
            ptr   <= ptr_dec;
            count <= count - 1'b1;
        end
    end

    // Entry contents need no reset.
    always_ff @(posedge clk) begin
        if (!reset && push)
            mem[ptr] <= push_data;
    end

endmodule

// File: rtl/pc_unit.sv
// pc_unit: program counter with SEQ/BRANCH/CALL/RET next-PC selection and a
// circular return-address stack. Ports: clk, reset, pc_write, sel, target,
// pc, ras_count, ras_overflow, ras_underflow; with PC_ALIGN_CHECK_EN
// defined also misalign_err (misaligned target/return address, pc held).
module pc_unit
    import pc_pkg::*;
#(
    parameter int ADDR_W    = 32,
    parameter int RESET_VEC = 107,
    parameter int STEP      = 1,
    parameter int RAS_DEPTH = 4
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic                           pc_write,
    input  logic [1:0]                     sel,
    input  logic [ADDR_W-1:0]              target,
    output logic [ADDR_W-1:0]              pc,
    output logic [$clog2(RAS_DEPTH+1)-1:0] ras_count,
    output logic                           ras_overflow,
    output logic                           ras_underflow
`ifdef PC_ALIGN_CHECK_EN
    ,
    output logic                           misalign_err
`endif
);

    localparam logic [ADDR_W-1:0] INC = ADDR_W'(STEP);
    localparam logic [ADDR_W-1:0] RST = ADDR_W'(RESET_VEC);

    logic [ADDR_W-1:0] pc_next;
    logic [ADDR_W-1:0] pc_seq;
    logic [ADDR_W-1:0] pop_data;
    logic              push;
    logic              pop;
    logic              full;
    logic              empty;
    logic              ovf_next;
    logic              unf_next;
    logic              mis_next;
    logic              tgt_ok;
    logic              ret_ok;

    assign pc_seq = pc + INC;

`ifdef PC_ALIGN_CHECK_EN
    localparam logic [ADDR_W-1:0] MASK = ADDR_W'(STEP - 1);
    assign tgt_ok = ((target & MASK) == '0);
    assign ret_ok = ((pop_data & MASK) == '0);
`else
    assign tgt_ok = 1'b1;
    assign ret_ok = 1'b1;
`endif

    always_comb begin
        pc_next  = pc;
        push     = 1'b0;
        pop      = 1'b0;
        ovf_next = 1'b0;
        unf_next = 1'b0;
        mis_next = 1'b0;
        if (pc_write) begin
            unique case (sel)
                PC_SEQ: pc_next = pc_seq;
                PC_BRANCH: begin
                    if (tgt_ok) pc_next = target;
                    else        mis_next = 1'b1;
                end
                PC_CALL: begin
                    if (tgt_ok) begin
                        pc_next  = target;
                        push     = 1'b1;
                        ovf_next = full;
                    end else begin
                        mis_next = 1'b1;
                    end
                end
                PC_RET: begin
                    // An empty stack degrades RET to a sequential step.
                    if (empty) begin
                        pc_next  = pc_seq;
                        unf_next = 1'b1;
                    end else if (ret_ok) begin
                        pc_next = pop_data;
                        pop     = 1'b1;
                    end else begin
                        mis_next = 1'b1;
                    end
                end
                default: pc_next = pc;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            pc            <= RST;
            ras_overflow  <= 1'b0;
            ras_underflow <= 1'b0;
        end else begin
            pc            <= pc_next;
            ras_overflow  <= ovf_next;
            ras_underflow <= unf_next;
        end
    end

`ifdef PC_ALIGN_CHECK_EN
    always_ff @(posedge clk) begin
        if (reset) misalign_err <= 1'b0;
        else       misalign_err <= mis_next;
    end
`else
    logic unused_mis;
    assign unused_mis = mis_next;
`endif

    ras_stack #(
        .W     (ADDR_W),
        .DEPTH (RAS_DEPTH)
    ) u_ras (
        .clk       (clk),
        .reset     (reset),
        .push      (push),
        .pop       (pop),
        .push_data (pc_seq),
        .pop_data  (pop_data),
        .count     (ras_count),
        .full      (full),
        .empty     (empty)
    );

endmodule
